// File: rtl/gain_spectrum_collector.sv
// gain_spectrum_collector
//   Collects the per-bin gain stream from the cal stage into frames of
//   N_POINTS bins. Each frame is stored in one half of a ping-pong RAM. The
//   block tracks the peak gain and its bin inside [PEAK_LO, PEAK_HI], and
//   publishes the last completed frame for random-access readout while the
//   next frame is written into the other half.
//
// Ports
//   clk, rst_n     system clock (rising edge), async active-low reset
//   gain/calvalid  gain sample stream, one bin per valid cycle, bin order
//   frame_clr      synchronous resync, discards the partial frame
//   rd_en/rd_addr  read request into the last completed frame
//   rd_data/rd_valid  read result, one cycle after the request
//   peak_gain/peak_bin  peak of the last completed frame
//   frame_done     one-cycle pulse when a frame completes
//   result_valid   at least one frame completed since reset
//   frame_cnt      completed frames, wraps at 16 bits
//
// state   | meaning
// --------+---------------------------------------------------------
// S_EMPTY | no frame completed since reset; reads return zero
// S_READY | a completed frame is published in the read bank

module gain_spectrum_collector #(
  parameter int N_POINTS = 1024,
  parameter int ADDR_W   = 10,
  parameter int GAIN_W   = 24,
  parameter int PEAK_LO  = 1,
  parameter int PEAK_HI  = 511
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GAIN_W-1:0] gain,
  input  logic              calvalid,
  input  logic              frame_clr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [GAIN_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [GAIN_W-1:0] peak_gain,
  output logic [ADDR_W-1:0] peak_bin,
  output logic              frame_done,
  output logic              result_valid,
  output logic [15:0]       frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W-1:0] PEAK_LO_A = ADDR_W'(PEAK_LO);
  localparam logic [ADDR_W-1:0] PEAK_HI_A = ADDR_W'(PEAK_HI);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]   bin_cnt_q, bin_cnt_d;
  logic [GAIN_W-1:0]   run_max_q, run_max_d;
  logic [ADDR_W-1:0]   run_bin_q, run_bin_d;
  logic [GAIN_W-1:0]   peak_gain_q, peak_gain_d;
  logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
  logic                frame_done_q, frame_done_d;
  logic                result_valid_q, result_valid_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [GAIN_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  // Both banks live in one array; the top address bit selects the bank.
  logic [GAIN_W-1:0]   mem_bank [2*N_POINTS];

  logic                wr_en;
  logic [ADDR_W:0]     wr_idx;
  logic [ADDR_W:0]     rd_idx;
  logic                in_win;
  logic                take;
  logic                frame_end;
  logic [GAIN_W-1:0]   cand_max;
  logic [ADDR_W-1:0]   cand_bin;

  // A sample that coincides with frame_clr is dropped entirely.
  assign wr_en  = calvalid && !frame_clr;
  assign wr_idx = {wr_bank_q, bin_cnt_q};
  // Reads always hit the bank not being written, so a read in the frame-end
  // cycle still sees the previous frame.
  assign rd_idx = {~wr_bank_q, rd_addr};

  assign in_win    = (bin_cnt_q >= PEAK_LO_A) && (bin_cnt_q <= PEAK_HI_A);
  // Strictly greater keeps the lowest bin on ties.
  assign take      = in_win && (gain > run_max_q);
  assign frame_end = wr_en && (bin_cnt_q == LAST_BIN);
  assign cand_max  = take ? gain : run_max_q;
  assign cand_bin  = take ? bin_cnt_q : run_bin_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_bank[wr_idx] <= gain;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    bin_cnt_d      = bin_cnt_q;
    run_max_d      = run_max_q;
    run_bin_d      = run_bin_q;
    peak_gain_d    = peak_gain_q;
    peak_bin_d     = peak_bin_q;
    frame_done_d   = 1'b0;
    result_valid_d = result_valid_q;
    frame_cnt_d    = frame_cnt_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = rd_en;

    if (frame_clr) begin
      bin_cnt_d = '0;
      run_max_d = '0;
      run_bin_d = PEAK_LO_A;
    end else if (calvalid) begin
      bin_cnt_d = bin_cnt_q + 1'b1;
      run_max_d = cand_max;
      run_bin_d = cand_bin;
      if (frame_end) begin
        wr_bank_d      = ~wr_bank_q;
        peak_gain_d    = cand_max;
        peak_bin_d     = cand_bin;
        run_max_d      = '0;
        run_bin_d      = PEAK_LO_A;
        result_valid_d = 1'b1;
        frame_cnt_d    = frame_cnt_q + 16'd1;
        frame_done_d   = 1'b1;
      end
    end

    case (state_q)
      S_EMPTY: if (frame_end) state_d = S_READY;
      S_READY: state_d = S_READY;
      default: state_d = S_EMPTY;
    endcase

    // Before the first frame the read bank holds stale data, so mask it.
    if (rd_en) begin
      rd_data_d = (state_q == S_READY) ? mem_bank[rd_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_EMPTY;
      wr_bank_q      <= 1'b0;
      bin_cnt_q      <= '0;
      run_max_q      <= '0;
      run_bin_q      <= PEAK_LO_A;
      peak_gain_q    <= '0;
      peak_bin_q     <= '0;
      frame_done_q   <= 1'b0;
      result_valid_q <= 1'b0;
      frame_cnt_q    <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      bin_cnt_q      <= bin_cnt_d;
      run_max_q      <= run_max_d;
      run_bin_q      <= run_bin_d;
      peak_gain_q    <= peak_gain_d;
      peak_bin_q     <= peak_bin_d;
      frame_done_q   <= frame_done_d;
      result_valid_q <= result_valid_d;
      frame_cnt_q    <= frame_cnt_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign peak_gain    = peak_gain_q;
  assign peak_bin     = peak_bin_q;
  assign frame_done   = frame_done_q;
  assign result_valid = result_valid_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_gain_spectrum_collector.sv
// Directed bench for gain_spectrum_collector. Expected read data and frame
// results are queued when stimulus is driven and compared when the DUT
// presents rd_valid / frame_done.

module tb_gain_spectrum_collector;

  localparam int N = 1024;

  logic        clk;
  logic        rst_n;
  logic [23:0] gain;
  logic        calvalid;
  logic        frame_clr;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic [23:0] peak_gain;
  logic [9:0]  peak_bin;
  logic        frame_done;
  logic        result_valid;
  logic [15:0] frame_cnt;

  gain_spectrum_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gain         (gain),
    .calvalid     (calvalid),
    .frame_clr    (frame_clr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .peak_gain    (peak_gain),
    .peak_bin     (peak_bin),
    .frame_done   (frame_done),
    .result_valid (result_valid),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [23:0] data;
    int          due;
  } rd_exp_t;

  typedef struct {
    logic [23:0] pgain;
    logic [9:0]  pbin;
    logic [15:0] cnt;
    int          due;
  } fr_exp_t;

  rd_exp_t rd_q[$];
  fr_exp_t fr_q[$];

  // reference model
  logic [23:0] ref_mem [2*N];
  logic        m_ready;
  logic        m_wbank;
  logic [9:0]  m_bin;
  logic [23:0] m_max;
  logic [9:0]  m_pbin;
  logic [15:0] m_fcnt;
  logic [23:0] rd_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_wbank = 1'b0;
    m_bin   = '0;
    m_max   = '0;
    m_pbin  = 10'd1;
    m_fcnt  = '0;
    rd_hold = '0;
    rd_q.delete();
    fr_q.delete();
  endtask

  task automatic step(input logic v, input logic [23:0] g, input logic clr,
                      input logic re, input logic [9:0] ra);
    rd_exp_t r;
    fr_exp_t f;
    calvalid  = v;
    gain      = g;
    frame_clr = clr;
    rd_en     = re;
    rd_addr   = ra;
    if (re) begin
      r.data = m_ready ? ref_mem[{~m_wbank, ra}] : 24'd0;
      r.due  = cyc + 1;
      rd_q.push_back(r);
    end
    if (clr) begin
      m_bin  = '0;
      m_max  = '0;
      m_pbin = 10'd1;
    end else if (v) begin
      ref_mem[{m_wbank, m_bin}] = g;
      if (m_bin >= 10'd1 && m_bin <= 10'd511 && g > m_max) begin
        m_max  = g;
        m_pbin = m_bin;
      end
      if (m_bin == 10'd1023) begin
        m_fcnt  = m_fcnt + 16'd1;
        f.pgain = m_max;
        f.pbin  = m_pbin;
        f.cnt   = m_fcnt;
        f.due   = cyc + 1;
        fr_q.push_back(f);
        m_wbank = ~m_wbank;
        m_ready = 1'b1;
        m_max   = '0;
        m_pbin  = 10'd1;
      end
      m_bin = m_bin + 10'd1;
    end
    @(posedge clk);
    #1;
    calvalid  = 1'b0;
    frame_clr = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'd0, 1'b0, 1'b0, 10'd0);
  endtask

  function automatic logic [23:0] f1(input int i);
    return (i == 100) ? 24'h7FFFFF : 24'(i);
  endfunction

  function automatic logic [23:0] f2(input int i);
    if (i == 0 || i == 600) return 24'hFFFFFF;
    if (i == 200 || i == 300) return 24'h000500;
    return 24'd1;
  endfunction

  function automatic logic [23:0] f4p(input int i);
    return (i == 50) ? 24'hABCDEF : 24'(i);
  endfunction

  function automatic logic [23:0] f4(input int i);
    return (i == 10) ? 24'h001000 : 24'(i & 255);
  endfunction

  // output monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          rd_exp_t r;
          r = rd_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(r.data));
          chk("rd_latency", 32'(cyc), 32'(r.due));
          rd_hold = r.data;
        end
      end else begin
        chk("rd_hold", 32'(rd_data), 32'(rd_hold));
      end
      if (frame_done) begin
        chk("frame_expected", 32'(fr_q.size() != 0), 32'd1);
        if (fr_q.size() != 0) begin
          fr_exp_t f;
          f = fr_q.pop_front();
          chk("peak_gain", 32'(peak_gain), 32'(f.pgain));
          chk("peak_bin", 32'(peak_bin), 32'(f.pbin));
          chk("frame_cnt", 32'(frame_cnt), 32'(f.cnt));
          chk("result_valid", 32'(result_valid), 32'd1);
          chk("frame_done_time", 32'(cyc), 32'(f.due));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_peak_gain"}, 32'(peak_gain), 32'd0);
    chk({tag, "_peak_bin"}, 32'(peak_bin), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    gain      = '0;
    calvalid  = 1'b0;
    frame_clr = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // frame 1: gain = bin, spike at 100; one read while still empty
    for (int i = 0; i < N; i++)
      step(1'b1, f1(i), 1'b0, (i == 5), 10'd5);
    idle(2);
    chk("f1_peak_bin", 32'(peak_bin), 32'd100);
    chk("f1_peak_gain", 32'(peak_gain), 32'h7FFFFF);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("f1_result_valid", 32'(result_valid), 32'd1);
    chk("f1_done_cleared", 32'(frame_done), 32'd0);

    // frame 2: tie / window frame while reading every bin back-to-back
    for (int i = 0; i < N; i++)
      step(1'b1, f2(i), 1'b0, (i >= 512), 10'(i - 512));
    for (int a = 512; a < N; a++)
      step(1'b0, 24'd0, 1'b0, 1'b1, 10'(a));
    idle(2);
    chk("f2_peak_bin", 32'(peak_bin), 32'd200);
    chk("f2_peak_gain", 32'(peak_gain), 32'h000500);
    chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);

    // frame 3: calvalid pattern 1-0-0
    for (int i = 0; i < N; i++) begin
      step(1'b1, f1(i), 1'b0, 1'b0, 10'd0);
      idle(2);
    end
    chk("f3_peak_bin", 32'(peak_bin), 32'd100);
    chk("f3_frame_cnt", 32'(frame_cnt), 32'd3);
    step(1'b0, 24'd0, 1'b0, 1'b1, 10'd100);
    step(1'b0, 24'd0, 1'b0, 1'b1, 10'd7);
    idle(2);

    // frame_clr after 500 samples, clashing with a sample
    for (int i = 0; i < 500; i++)
      step(1'b1, f4p(i), 1'b0, 1'b0, 10'd0);
    step(1'b1, 24'hFFFFFF, 1'b1, 1'b0, 10'd0);
    for (int i = 0; i < N; i++)
      step(1'b1, f4(i), 1'b0, 1'b0, 10'd0);
    idle(1);
    chk("f4_peak_bin", 32'(peak_bin), 32'd10);
    chk("f4_peak_gain", 32'(peak_gain), 32'h001000);
    chk("f4_frame_cnt", 32'(frame_cnt), 32'd4);
    step(1'b0, 24'd0, 1'b0, 1'b1, 10'd0);
    step(1'b0, 24'd0, 1'b0, 1'b1, 10'd10);
    step(1'b0, 24'd0, 1'b0, 1'b1, 10'd50);
    idle(2);

    // async reset in the middle of a frame
    for (int i = 0; i < 300; i++)
      step(1'b1, f1(i), 1'b0, 1'b0, 10'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 24'd0, 1'b0, 1'b1, 10'd5);
    idle(3);
    chk("post_reset_result_valid", 32'(result_valid), 32'd0);
    chk("post_reset_frame_cnt", 32'(frame_cnt), 32'd0);

    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("frame_queue_drained", 32'(fr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
